// File: rtl/iob_fifo_ctrl_pkg.sv
// iob_fifo_ctrl_pkg
// Shared constants and types for the 2-port RAM FIFO controller.
// The defaults below describe the standard build (32-bit words, 16 entries).
// A pointer carries one more bit than the RAM address. That extra wrap bit
// separates "full" from "empty" when the address bits are equal.
// Optional feature macro used by the top: IOB_FIFO_CTRL_ERR_EN.
package iob_fifo_ctrl_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // Pointer width and FIFO depth derived from the default address width
  localparam int PTR_W = DEF_ADDR_W + 1;
  localparam int DEPTH = 2 ** DEF_ADDR_W;

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/iob_fifo_ptr.sv
// iob_fifo_ptr
// Wrapping binary counter for one FIFO pointer (write or read side).
// Ports:
//   clk_i     in   clock
//   arst_n_i  in   asynchronous reset, active-low, clears the pointer to 0
//   inc_i     in   advance the pointer by one on the next clock edge
//   ptr_o     out  current pointer value; the MSB is the wrap bit
module iob_fifo_ptr
  import iob_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = PTR_W
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] ptr_o
);

  logic [WIDTH-1:0] r_ptr;

  // The counter rolls over naturally. The low bits return to 0 and the
  // wrap bit toggles, which is what the full/empty compare relies on.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ptr <= '0;
    end else if (inc_i) begin
      r_ptr <= r_ptr + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/iob_fifo_ctrl_2p.sv
// iob_fifo_ctrl_2p
// Synchronous FIFO controller for an external 2-port RAM. The RAM has one
// write port and one registered read port with 1-cycle latency.
// Ports:
//   clk_i / arst_n_i        clock, asynchronous active-low reset
//   w_en_i, w_data_i        push request and data
//   w_full_o                FIFO full
//   r_en_i                  pop request
//   r_data_o, r_valid_o     popped word, valid one cycle after an accepted pop
//   r_empty_o, level_o      FIFO empty, occupancy 0..2**ADDR_W
//   ext_mem_w_*             RAM write port drive (combinational)
//   ext_mem_r_en_o/_addr_o  RAM read port drive (combinational)
//   ext_mem_r_data_i        RAM read data, one cycle after ext_mem_r_en_o
//   ovf_o, unf_o            sticky overflow/underflow flags, present only
//                           when the macro IOB_FIFO_CTRL_ERR_EN is defined
module iob_fifo_ctrl_2p
  import iob_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              w_en_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_full_o,
  input  logic              r_en_i,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_valid_o,
  output logic              r_empty_o,
  output logic [ADDR_W:0]   level_o,
  output logic              ext_mem_w_en_o,
  output logic [ADDR_W-1:0] ext_mem_w_addr_o,
  output logic [DATA_W-1:0] ext_mem_w_data_o,
  output logic              ext_mem_r_en_o,
  output logic [ADDR_W-1:0] ext_mem_r_addr_o,
  input  logic [DATA_W-1:0] ext_mem_r_data_i
`ifdef IOB_FIFO_CTRL_ERR_EN
  ,
  output logic              ovf_o,
  output logic              unf_o
`endif
);

  localparam int PTR_BITS = ADDR_W + 1;

  logic [PTR_BITS-1:0] w_wrPtr;
  logic [PTR_BITS-1:0] w_rdPtr;
  logic                w_full;
  logic                w_empty;
  logic                w_pushAcc;
  logic                w_popAcc;
  logic                r_rdValid;

  // Flags come straight from the registered pointers. They therefore
  // change in the cycle after an accepted push or pop.
  assign w_empty = (w_wrPtr == w_rdPtr);
  assign w_full  = (w_wrPtr[ADDR_W] != w_rdPtr[ADDR_W]) &&
                   (w_wrPtr[ADDR_W-1:0] == w_rdPtr[ADDR_W-1:0]);

  // A push while full is rejected. This still holds when a pop happens in
  // the same cycle, because nothing passes straight through. A pop while
  // empty is rejected in the same way.
  assign w_pushAcc = w_en_i & ~w_full;
  assign w_popAcc  = r_en_i & ~w_empty;

  iob_fifo_ptr #(.WIDTH(PTR_BITS)) u_wrPtr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .inc_i    (w_pushAcc),
    .ptr_o    (w_wrPtr)
  );

  iob_fifo_ptr #(.WIDTH(PTR_BITS)) u_rdPtr (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .inc_i    (w_popAcc),
    .ptr_o    (w_rdPtr)
  );

  // The RAM read port returns data one cycle after the read enable.
  // This register marks the cycle in which that data is on the bus.
  // Reset drops it at once, so an in-flight read is discarded.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_popAcc;
    end
  end

  assign w_full_o  = w_full;
  assign r_empty_o = w_empty;
  assign level_o   = w_wrPtr - w_rdPtr;
  assign r_valid_o = r_rdValid;
  assign r_data_o  = ext_mem_r_data_i;

  assign ext_mem_w_en_o   = w_pushAcc;
  assign ext_mem_w_addr_o = w_wrPtr[ADDR_W-1:0];
  assign ext_mem_w_data_o = w_data_i;
  assign ext_mem_r_en_o   = w_popAcc;
  assign ext_mem_r_addr_o = w_rdPtr[ADDR_W-1:0];

`ifdef IOB_FIFO_CTRL_ERR_EN
  logic r_ovf;
  logic r_unf;

  // Sticky error flags. Each one records that a request arrived while the
  // FIFO could not take it. Only reset clears them.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_en_i && w_full) begin
        r_ovf <= 1'b1;
      end
      if (r_en_i && w_empty) begin
        r_unf <= 1'b1;
      end
    end
  end

  assign ovf_o = r_ovf;
  assign unf_o = r_unf;
`endif

endmodule
